// File: rtl/zad1_compare.sv
// zad1_compare: registered, glitch-filtered unsigned magnitude comparator.
// Ports: clk, rst (async, active-high), IN1/IN2 (WIDTH-bit operands),
//        out (registered, filtered "IN1 > IN2").
// Optional hysteresis margin HYST is compiled in by defining ZAD1_HYST_EN.
module zad1_compare #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 4,
  parameter int HYST       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic             out
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [CW-1:0]    cnt;
  logic             target;

  // Stage 1: operand capture. Cleared operands compare equal, so leaving
  // reset never produces a spurious mismatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
    end else begin
      in1_q <= IN1;
      in2_q <= IN2;
    end
  end

  // Stage 2: raw target bit.
`ifdef ZAD1_HYST_EN
  // Sums are one bit wider than the operands so adding the margin cannot wrap.
  localparam logic [WIDTH:0] HYST_W = (WIDTH+1)'(HYST);

  logic [WIDTH:0] in1_x;
  logic [WIDTH:0] in2_x;

  assign in1_x = {1'b0, in1_q};
  assign in2_x = {1'b0, in2_q};

  // The threshold to leave the current state depends on that state, giving
  // a dead band of HYST on either side of equality.
  always_comb begin
    target = out;
    if (!out) begin
      if (in1_x > in2_x + HYST_W) target = 1'b1;
    end else begin
      if (in1_x + HYST_W < in2_x) target = 1'b0;
    end
  end
`else
  // Without hysteresis the margin has no role; it only qualifies as a sane
  // (non-negative) value here, which folds to a constant.
  localparam logic HYST_OK = (HYST >= 0);

  always_comb begin
    target = (in1_q > in2_q) & HYST_OK;
  end
`endif

  // Persistence filter: out follows target only after FILTER_LEN consecutive
  // mismatching cycles; any agreeing cycle discards the partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (target == out) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      out <= target;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_zad1_compare.sv
// tb_zad1_compare: directed bench for zad1_compare with a behavioural model
// checked on every falling edge plus hand-computed literal expectations.
// Define ZAD1_HYST_EN to run the hysteresis scenario (FILTER_LEN=1).
module tb_zad1_compare;

`ifdef ZAD1_HYST_EN
  localparam int FL = 1;
`else
  localparam int FL = 4;
`endif
  localparam int HY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  zad1_compare #(
    .WIDTH     (8),
    .FILTER_LEN(FL),
    .HYST      (HY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .IN1(in1),
    .IN2(in2),
    .out(out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Result of comparing the operands sampled one edge earlier, given the
  // current output (only matters with hysteresis).
  function automatic logic tgt(input int a, input int b, input logic o);
`ifdef ZAD1_HYST_EN
    if (!o) return (a > b + HY);
    else    return !(a + HY < b);
`else
    return (a > b);
`endif
  endfunction

  int   mq1  = 0;
  int   mq2  = 0;
  logic mout = 1'b0;
  logic mt;
  logic hist[$];   // run of consecutive cycles disagreeing with mout

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq1  = 0;
      mq2  = 0;
      mout = 1'b0;
      hist.delete();
    end else begin
      mt = tgt(mq1, mq2, mout);
      if (mt !== mout) begin
        hist.push_back(mt);
        if (hist.size() == FL) begin
          mout = mt;
          hist.delete();
        end
      end else begin
        hist.delete();
      end
      mq1 = int'(in1);
      mq2 = int'(in2);
    end
  end

  always @(negedge clk) check("model_out", {31'd0, out}, {31'd0, mout});

  // ---------------- directed stimulus ----------------
  // Caller has just driven the inputs; the next edge samples them (edge e).
  // out must hold its old value through e+FL-1 and take newv at e+FL.
  task automatic wait_toggle(input logic newv, input string nm);
    @(posedge clk);
    for (int i = 1; i <= FL; i++) begin
      @(posedge clk);
      #1;
      check(nm, {31'd0, out}, (i < FL) ? {31'd0, ~newv} : {31'd0, newv});
    end
  endtask

  task automatic expect_toggle(input logic [7:0] a, input logic [7:0] b,
                               input logic newv, input string nm);
    in1 = a;
    in2 = b;
    wait_toggle(newv, nm);
  endtask

  task automatic hold(input logic [7:0] a, input logic [7:0] b, input int n,
                      input logic expv, input string nm);
    in1 = a;
    in2 = b;
    repeat (n) @(posedge clk);
    #1;
    check(nm, {31'd0, out}, {31'd0, expv});
  endtask

  initial begin
    rst = 1'b1;
    in1 = 8'hFF;
    in2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("out_in_reset", {31'd0, out}, 32'd0);
    check("cnt_in_reset", 32'(dut.cnt), 32'd0);
    rst = 1'b0;
    wait_toggle(1'b1, "reset_release_rise");

`ifndef ZAD1_HYST_EN
    expect_toggle(8'd50,  8'd100, 1'b0, "fall_50_100");
    expect_toggle(8'd100, 8'd50,  1'b1, "rise_100_50");
    expect_toggle(8'd50,  8'd100, 1'b0, "fall2_50_100");

    // Glitch: three cycles of 200>10 then equal operands.
    in1 = 8'd200;
    in2 = 8'd10;
    repeat (3) @(posedge clk);
    #1;
    in1 = 8'd10;
    in2 = 8'd10;
    @(posedge clk);
    #1;
    check("glitch_cnt_peak", 32'(dut.cnt), 32'd3);
    check("glitch_out_peak", {31'd0, out}, 32'd0);
    @(posedge clk);
    #1;
    check("glitch_cnt_clear", 32'(dut.cnt), 32'd0);
    check("glitch_out_hold", {31'd0, out}, 32'd0);
    hold(8'd10, 8'd10, 4, 1'b0, "glitch_out_settled");

    // Boundaries.
    hold(8'hFF, 8'hFF, FL + 2, 1'b0, "eq_ff_ff");
    expect_toggle(8'hFF, 8'hFE, 1'b1, "ff_gt_fe");
    expect_toggle(8'h00, 8'hFF, 1'b0, "00_lt_ff");

    // Reset pulse between edges with a rise pending at cnt=2.
    in1 = 8'd100;
    in2 = 8'd50;
    repeat (3) @(posedge clk);
    #1;
    check("mid_cnt_before", 32'(dut.cnt), 32'd2);
    check("mid_out_before", {31'd0, out}, 32'd0);
    #3 rst = 1'b1;
    #1;
    check("mid_cnt_async", 32'(dut.cnt), 32'd0);
    check("mid_out_async", {31'd0, out}, 32'd0);
    #1 rst = 1'b0;
    wait_toggle(1'b1, "after_mid_reset_rise");
`else
    expect_toggle(8'd0,  8'd255, 1'b0, "hyst_clear_setup");
    hold(8'd12, 8'd10, 3, 1'b0, "hyst_12_10_hold0");
    expect_toggle(8'd13, 8'd10, 1'b1, "hyst_13_10_set");
    hold(8'd9,  8'd10, 3, 1'b1, "hyst_9_10_hold1");
    expect_toggle(8'd7,  8'd10, 1'b0, "hyst_7_10_clear");
`endif

    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
